// File: rtl/relu_maxpool_pkg.sv
// Shared helpers for the ReLU + max-pool stage: sizing functions and the
// signed ReLU / max primitives, evaluated at a fixed wide width.
package relu_maxpool_pkg;

   localparam int unsigned W_MAX = 64;

   typedef logic signed [W_MAX-1:0] wide_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Callers sign-extend their T-bit values into wide_t, so results truncate back losslessly.
   function automatic wide_t relu_f(input wide_t x, input bit en);
      return (en && x[W_MAX-1]) ? '0 : x;
   endfunction

   function automatic wide_t smax_f(input wide_t a, input wide_t b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/relu_maxpool_fifo_out.sv
// Output FIFO for pooled results: circular buffer, occupancy counter,
// registered storage; push and pop in the same cycle are both honoured.
module fifo_out
   import relu_maxpool_pkg::*;
#(
   parameter int unsigned T     = 20,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [T-1:0] push_data,
   output logic         full,
   input  logic         pop,
   output logic         empty,
   output logic [T-1:0] head_data
);

   localparam int unsigned PTR_W = clog2_min1(DEPTH);

   logic [T-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      full    = (cnt_q == (PTR_W+1)'(DEPTH));
      empty   = (cnt_q == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is deliberately left out of reset; validity is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_q] <= push_data;
   end

   assign head_data = mem_q[rd_q];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by non-overlapping K-sample max-pooling on the conv output
// stream; one pooled result per window is queued in a small output FIFO.
module relu_maxpool
   import relu_maxpool_pkg::*;
#(
   parameter int unsigned T       = 20,
   parameter int unsigned VECLEN  = 8,
   parameter int unsigned K       = 2,
   parameter bit          RELU_EN = 1'b1,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [T-1:0] s_data_in_y,
   input  logic                s_valid_y,
   output logic                s_ready_y,
   output logic signed [T-1:0] m_data_out_z,
   output logic                m_valid_z,
   input  logic                m_ready_z
);

   localparam int unsigned CNT_W = clog2_min1(K);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   if (K < 1 || (VECLEN % K) != 0) begin : g_bad_k
      $error("relu_maxpool: K must be >= 1 and divide VECLEN");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("relu_maxpool: DEPTH must be a power of two >= 2");
   end
   if (T < 2 || T > W_MAX) begin : g_bad_t
      $error("relu_maxpool: T out of supported range");
   end

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic signed [T-1:0] max_q, max_d;
   logic signed [T-1:0] r, win_max;
   wide_t               r_w, max_w;
   logic                accept, last, push;
   logic                fifo_full, fifo_empty;
   logic [T-1:0]        head_data;

   always_comb begin
      r_w     = relu_f(W_MAX'(s_data_in_y), RELU_EN);
      r       = r_w[T-1:0];
      max_w   = smax_f(W_MAX'(max_q), r_w);
      win_max = (cnt_q == '0) ? r : max_w[T-1:0];
   end

   // Ready only looks at registers: a full FIFO stalls just the window-closing sample.
   assign last      = (cnt_q == CNT_LAST);
   assign s_ready_y = !last || !fifo_full;
   assign accept    = s_valid_y && s_ready_y;
   assign push      = accept && last;

   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      if (accept) begin
         max_d = win_max;
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         max_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         max_q <= max_d;
      end
   end

   fifo_out #(
      .T     (T),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (win_max),
      .full      (fifo_full),
      .pop       (m_ready_z),
      .empty     (fifo_empty),
      .head_data (head_data)
   );

   assign m_valid_z    = !fifo_empty;
   assign m_data_out_z = head_data;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed and random checks of relu_maxpool with ReLU on and off side by side.
module tb_relu_maxpool;

   localparam int T = 20;
   localparam int K = 2;

   logic                clk;
   logic                reset;
   logic signed [T-1:0] s_data;
   logic                s_valid;
   logic                m_ready;
   logic                s_ready_1, s_ready_0;
   logic                m_valid_1, m_valid_0;
   logic signed [T-1:0] m_data_1, m_data_0;

   int n_cmp  = 0;
   int n_fail = 0;
   bit rnd_en = 1'b0;

   logic signed [T-1:0] got1[$], got0[$], exp1[$], exp0[$];
   logic signed [T-1:0] win[K];
   int                  wn = 0;

   typedef struct {
      logic signed [T-1:0] x;
      bit                  mv;
      logic signed [T-1:0] d1;
      logic signed [T-1:0] d0;
   } row_t;
   row_t tbl[12];

   relu_maxpool #(.T(T), .VECLEN(8), .K(K), .RELU_EN(1'b1), .DEPTH(4)) dut1 (
      .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
      .s_ready_y(s_ready_1), .m_data_out_z(m_data_1), .m_valid_z(m_valid_1),
      .m_ready_z(m_ready));

   relu_maxpool #(.T(T), .VECLEN(8), .K(K), .RELU_EN(1'b0), .DEPTH(4)) dut0 (
      .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
      .s_ready_y(s_ready_0), .m_data_out_z(m_data_0), .m_valid_z(m_valid_0),
      .m_ready_z(m_ready));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && m_ready) begin
            if (m_valid_1) got1.push_back(m_data_1);
            if (m_valid_0) got0.push_back(m_data_0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic chk_val(input string name, input logic signed [T-1:0] act,
                          input logic signed [T-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [T-1:0] relu_m(input logic signed [T-1:0] v, input bit en);
      return (en && v < 0) ? '0 : v;
   endfunction

   // Golden model: collect a whole window, then take the max of the window.
   task automatic model_in(input logic signed [T-1:0] x);
      logic signed [T-1:0] m1, m0;
      win[wn] = x;
      wn++;
      if (wn == K) begin
         m1 = relu_m(win[0], 1'b1);
         m0 = win[0];
         for (int i = 1; i < K; i++) begin
            if (relu_m(win[i], 1'b1) > m1) m1 = relu_m(win[i], 1'b1);
            if (win[i] > m0) m0 = win[i];
         end
         exp1.push_back(m1);
         exp0.push_back(m0);
         wn = 0;
      end
   endtask

   task automatic clear_sb();
      got1.delete(); got0.delete(); exp1.delete(); exp0.delete();
      wn = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_sb();
   endtask

   task automatic send(input logic signed [T-1:0] x);
      int n = 0;
      s_valid = 1'b1;
      s_data  = x;
      @(negedge clk);
      while (!s_ready_1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready_1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: s_ready_y stuck at %b, required 1", s_ready_1);
      end else begin
         model_in(x);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      m_ready = 1'b1;
      @(negedge clk);
      while (m_valid_1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (m_valid_1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: m_valid_z still %b, required 0", m_valid_1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_sb(input string name);
      chk_int({name, "_count1"}, got1.size(), exp1.size());
      chk_int({name, "_count0"}, got0.size(), exp0.size());
      for (int i = 0; i < got1.size() && i < exp1.size(); i++)
         chk_val($sformatf("%s_relu[%0d]", name, i), got1[i], exp1[i]);
      for (int i = 0; i < got0.size() && i < exp0.size(); i++)
         chk_val($sformatf("%s_raw[%0d]", name, i), got0[i], exp0[i]);
      clear_sb();
   endtask

   initial begin
      logic signed [T-1:0] x;

      tbl[0]  = '{20'sd5,       1'b0, 20'sd0,   20'sd0};
      tbl[1]  = '{-20'sd3,      1'b1, 20'sd5,   20'sd5};
      tbl[2]  = '{-20'sd7,      1'b0, 20'sd0,   20'sd0};
      tbl[3]  = '{-20'sd2,      1'b1, 20'sd0,   -20'sd2};
      tbl[4]  = '{20'sd100,     1'b0, 20'sd0,   20'sd0};
      tbl[5]  = '{20'sd99,      1'b1, 20'sd100, 20'sd100};
      tbl[6]  = '{20'sd0,       1'b0, 20'sd0,   20'sd0};
      tbl[7]  = '{20'sd1,       1'b1, 20'sd1,   20'sd1};
      tbl[8]  = '{-20'sd7,      1'b0, 20'sd0,   20'sd0};
      tbl[9]  = '{-20'sd2,      1'b1, 20'sd0,   -20'sd2};
      tbl[10] = '{20'sh80000,   1'b0, 20'sd0,   20'sd0};
      tbl[11] = '{20'sh80001,   1'b1, 20'sd0,   20'sh80001};

      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_bit("reset_m_valid_relu", m_valid_1, 1'b0);
      chk_bit("reset_m_valid_raw",  m_valid_0, 1'b0);
      chk_bit("reset_s_ready_relu", s_ready_1, 1'b1);
      chk_bit("reset_s_ready_raw",  s_ready_0, 1'b1);
      reset = 1'b0;

      // Back-to-back stream with downstream always ready: per-cycle latency check.
      for (int i = 0; i < 12; i++) begin
         s_valid = 1'b1;
         s_data  = tbl[i].x;
         chk_bit($sformatf("tbl%0d_s_ready_relu", i), s_ready_1, 1'b1);
         chk_bit($sformatf("tbl%0d_s_ready_raw", i),  s_ready_0, 1'b1);
         @(posedge clk);
         #1;
         chk_bit($sformatf("tbl%0d_m_valid_relu", i), m_valid_1, tbl[i].mv);
         chk_bit($sformatf("tbl%0d_m_valid_raw", i),  m_valid_0, tbl[i].mv);
         if (tbl[i].mv) begin
            chk_val($sformatf("tbl%0d_data_relu", i), m_data_1, tbl[i].d1);
            chk_val($sformatf("tbl%0d_data_raw", i),  m_data_0, tbl[i].d0);
         end
      end
      s_valid = 1'b0;

      // Backpressure: fill the FIFO, stall the window-closing sample, then release.
      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(T'(i));
      chk_bit("full_cnt0_s_ready", s_ready_1, 1'b1);
      chk_bit("full_m_valid",      m_valid_1, 1'b1);
      send(20'sd9);
      chk_bit("full_cnt1_s_ready", s_ready_1, 1'b0);
      chk_val("full_head",         m_data_1,  20'sd2);
      s_valid = 1'b1;
      s_data  = 20'sd10;
      repeat (3) @(posedge clk);
      #1;
      chk_bit("stall_s_ready", s_ready_1, 1'b0);
      chk_val("stall_head",    m_data_1,  20'sd2);
      chk_val("stall_head_raw", m_data_0, 20'sd2);
      m_ready = 1'b1;
      send(20'sd10);
      drain();
      chk_int("bp_count", got1.size(), 5);
      check_sb("bp");

      // Reset mid-window with two results pending.
      do_reset();
      m_ready = 1'b0;
      send(20'sd1); send(20'sd2); send(20'sd3); send(20'sd4); send(20'sd50);
      chk_bit("pre_reset_m_valid", m_valid_1, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_bit("mid_reset_m_valid_relu", m_valid_1, 1'b0);
      chk_bit("mid_reset_m_valid_raw",  m_valid_0, 1'b0);
      chk_bit("mid_reset_s_ready",      s_ready_1, 1'b1);
      reset = 1'b0;
      clear_sb();
      m_ready = 1'b1;
      send(20'sd3);
      send(20'sd4);
      drain();
      chk_int("post_reset_count", got1.size(), 1);
      if (got1.size() > 0) chk_val("post_reset_value", got1[0], 20'sd4);
      check_sb("post_reset");

      // Random valid gaps and random downstream ready over 500 vectors of 8.
      do_reset();
      rnd_en = 1'b1;
      for (int v = 0; v < 500; v++) begin
         for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
            case ($urandom_range(0, 9))
               0:       x = 20'sh80000;
               1:       x = 20'sh7FFFF;
               2:       x = '0;
               default: x = T'($urandom);
            endcase
            send(x);
         end
      end
      rnd_en = 1'b0;
      @(posedge clk);
      #1;
      drain();
      chk_int("rand_total", got1.size(), 2000);
      check_sb("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
